// File: rtl/dilithium_pkg.sv
// Shared Dilithium NTT datapath definitions: coefficient geometry and
// the writeback FSM encoding.
package dilithium_pkg;

    localparam int DIL_COEFF_W = 24;
    localparam int DIL_LANES   = 4;
    localparam int DIL_AW      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/bf_writeback_addr_fifo.sv
// In-flight destination-address queue for the butterfly writeback.
// Caller guarantees push is never asserted on a full queue without a pop.
module addr_fifo #(
    parameter int AW    = 6,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            din,
    output logic [AW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PW+1)'(1);
                2'b01:   cnt_d = cnt_q - (PW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/bf_writeback.sv
// Butterfly result writeback: pairs each result with its queued
// destination address and issues a registered coefficient-RAM write.
module bf_writeback
    import dilithium_pkg::*;
#(
    parameter int COEFF_W = DIL_COEFF_W,
    parameter int LANES   = DIL_LANES,
    parameter int AW      = DIL_AW,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_addr,
    input  logic                       issue_last,
    input  logic                       bf_valid,
    input  logic [LANES*COEFF_W-1:0]   bf_data,
    output logic                       wr_en,
    output logic [AW-1:0]              wr_addr,
    output logic [LANES*COEFF_W-1:0]   wr_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       done,
    output logic                       err_overflow,
    output logic                       err_underflow
);

    localparam int DW = LANES * COEFF_W;
    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_e     state_q, state_d;
    logic          last_q, last_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;

    logic          active;
    logic          fifo_push, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [AW-1:0] fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          ovf_evt, unf_evt, final_pop;

    addr_fifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (issue_addr),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // start discards the cycle's inputs; pops use pre-push occupancy
    always_comb begin
        active    = (state_q != ST_IDLE) && !start;
        fifo_pop  = active && bf_valid && !fifo_empty;
        fifo_push = (state_q == ST_RUN) && !start && issue_valid
                    && (!fifo_full || fifo_pop);
        ovf_evt   = !start && issue_valid
                    && (((state_q == ST_RUN) && fifo_full && !fifo_pop)
                        || (state_q == ST_DRAIN));
        unf_evt   = active && bf_valid && fifo_empty;
        final_pop = (state_q == ST_DRAIN) && last_q && fifo_pop
                    && (fifo_count == CW'(1));
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        err_ovf_d = err_ovf_q | ovf_evt;
        err_unf_d = err_unf_q | unf_evt;
        wr_en_d   = fifo_pop;
        wr_addr_d = fifo_pop ? fifo_dout : wr_addr_q;
        wr_data_d = fifo_pop ? bf_data : wr_data_q;
        done_d    = final_pop;
        unique case (state_q)
            ST_RUN: begin
                if (issue_valid && issue_last) begin
                    state_d = ST_DRAIN;
                    last_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (final_pop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d   = ST_RUN;
            last_d    = 1'b0;
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign pending       = fifo_count;
    assign done          = done_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_bf_writeback.sv
// Directed self-checking bench for bf_writeback.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_bf_writeback;

    logic        clk = 1'b0;
    logic        rst, start, issue_valid, issue_last, bf_valid;
    logic [5:0]  issue_addr;
    logic [95:0] bf_data;
    logic        wr_en, done, err_overflow, err_underflow;
    logic [5:0]  wr_addr;
    logic [95:0] wr_data;
    logic [4:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;

    bf_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .issue_last    (issue_last),
        .bf_valid      (bf_valid),
        .bf_data       (bf_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .pending       (pending),
        .done          (done),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] pat(input int i);
        return {24'(i * 3 + 7), 24'(i), 24'hABCDEF ^ 24'(i), 24'(i + 1)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start       = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        issue_last  = 1'b0;
        bf_valid    = 1'b0;
        bf_data     = '0;
    endtask

    task automatic do_start();
        idle_in();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        idle_in();
        rst   = 1'b1;
        start = 1'b1;
        step();
        step();
        rst   = 1'b0;
        start = 1'b0;
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
        n_tests++; if (wr_addr !== 6'd0) begin n_fail++; $display("FAIL rst_wr_addr got %0d want 0", wr_addr); end
        n_tests++; if (wr_data !== 96'd0) begin n_fail++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
        n_tests++; if (pending !== 5'd0) begin n_fail++; $display("FAIL rst_pending got %0d want 0", pending); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        n_tests++; if ({err_overflow, err_underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_err got %b want 00", {err_overflow, err_underflow}); end
        // start was held with rst, so the block must still be idle
        issue_valid = 1'b1;
        issue_addr  = 6'd3;
        bf_valid    = 1'b1;
        step();
        idle_in();
        n_tests++; if (pending !== 5'd0) begin n_fail++; $display("FAIL rst_prio_pending got %0d want 0", pending); end
        n_tests++; if ({wr_en, err_overflow, err_underflow} !== 3'b000) begin n_fail++; $display("FAIL rst_prio_idle got %b want 000", {wr_en, err_overflow, err_underflow}); end
    endtask

    task automatic test_basic();
        int bad;
        do_start();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            issue_addr  = 6'(5 + i);
            issue_last  = (i == 2);
            step();
        end
        idle_in();
        n_tests++; if (pending !== 5'd3) begin n_fail++; $display("FAIL basic_pending got %0d want 3", pending); end
        bad = 0;
        for (int c = 3; c < 10; c++) begin
            step();
            if (wr_en !== 1'b0 || done !== 1'b0) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL basic_quiet got %0d want 0", bad); end
        for (int i = 0; i < 3; i++) begin
            bf_valid = 1'b1;
            bf_data  = 96'(i + 1);
            step();
            n_tests++; if ({wr_en, wr_addr} !== {1'b1, 6'(5 + i)}) begin n_fail++; $display("FAIL basic_wr%0d got en=%b addr=%0d want en=1 addr=%0d", i, wr_en, wr_addr, 5 + i); end
            n_tests++; if (wr_data !== 96'(i + 1)) begin n_fail++; $display("FAIL basic_data%0d got %h want %h", i, wr_data, 96'(i + 1)); end
            n_tests++; if (done !== (i == 2)) begin n_fail++; $display("FAIL basic_done%0d got %b want %b", i, done, (i == 2)); end
        end
        idle_in();
        step();
        n_tests++; if ({wr_en, done, pending} !== 7'd0) begin n_fail++; $display("FAIL basic_after got en=%b done=%b pend=%0d want 0 0 0", wr_en, done, pending); end
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < 17; i++) begin
            issue_valid = 1'b1;
            issue_addr  = 6'(i);
            step();
            if (i == 15) begin
                n_tests++; if ({err_overflow, pending} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL ovf_at16 got ovf=%b pend=%0d want 0 16", err_overflow, pending); end
            end
        end
        idle_in();
        n_tests++; if (pending !== 5'd16) begin n_fail++; $display("FAIL ovf_pending got %0d want 16", pending); end
        n_tests++; if ({err_overflow, err_underflow} !== 2'b10) begin n_fail++; $display("FAIL ovf_flags got %b want 10", {err_overflow, err_underflow}); end
        for (int i = 0; i < 16; i++) begin
            bf_valid = 1'b1;
            bf_data  = pat(i);
            step();
            n_tests++; if ({wr_en, wr_addr} !== {1'b1, 6'(i)}) begin n_fail++; $display("FAIL ovf_drain%0d got en=%b addr=%0d want 1 %0d", i, wr_en, wr_addr, i); end
        end
        n_tests++; if (pending !== 5'd0) begin n_fail++; $display("FAIL ovf_empty got %0d want 0", pending); end
        // the dropped 17th address must not be there
        step();
        n_tests++; if ({wr_en, err_underflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_dropped got en=%b unf=%b want 0 1", wr_en, err_underflow); end
        idle_in();
    endtask

    task automatic test_full_swap();
        do_start();
        for (int i = 0; i < 16; i++) begin
            issue_valid = 1'b1;
            issue_addr  = 6'(20 + i);
            step();
        end
        n_tests++; if ({err_overflow, pending} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL swap_full got ovf=%b pend=%0d want 0 16", err_overflow, pending); end
        issue_addr = 6'd40;
        bf_valid   = 1'b1;
        bf_data    = pat(100);
        step();
        idle_in();
        n_tests++; if (pending !== 5'd16) begin n_fail++; $display("FAIL swap_pending got %0d want 16", pending); end
        n_tests++; if ({wr_en, wr_addr} !== {1'b1, 6'd20}) begin n_fail++; $display("FAIL swap_wr got en=%b addr=%0d want 1 20", wr_en, wr_addr); end
        n_tests++; if (wr_data !== pat(100)) begin n_fail++; $display("FAIL swap_data got %h want %h", wr_data, pat(100)); end
        n_tests++; if ({err_overflow, err_underflow} !== 2'b00) begin n_fail++; $display("FAIL swap_err got %b want 00", {err_overflow, err_underflow}); end
        for (int i = 0; i < 16; i++) begin
            bf_valid = 1'b1;
            step();
            n_tests++; if (wr_addr !== ((i < 15) ? 6'(21 + i) : 6'd40)) begin n_fail++; $display("FAIL swap_order%0d got %0d want %0d", i, wr_addr, (i < 15) ? 21 + i : 40); end
        end
        idle_in();
    endtask

    task automatic test_underflow();
        do_start();
        bf_valid = 1'b1;
        bf_data  = pat(7);
        step();
        idle_in();
        n_tests++; if ({err_underflow, wr_en, pending} !== {1'b1, 1'b0, 5'd0}) begin n_fail++; $display("FAIL unf_set got unf=%b en=%b pend=%0d want 1 0 0", err_underflow, wr_en, pending); end
        do_start();
        n_tests++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", err_underflow); end
        issue_valid = 1'b1;
        issue_addr  = 6'd9;
        bf_valid    = 1'b1;
        step();
        idle_in();
        n_tests++; if ({pending, err_underflow, wr_en} !== {5'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL unf_nobypass got pend=%0d unf=%b en=%b want 1 1 0", pending, err_underflow, wr_en); end
        bf_valid = 1'b1;
        bf_data  = pat(9);
        step();
        idle_in();
        n_tests++; if ({wr_en, wr_addr} !== {1'b1, 6'd9}) begin n_fail++; $display("FAIL unf_later got en=%b addr=%0d want 1 9", wr_en, wr_addr); end
    endtask

    task automatic test_rst_mid();
        int bad;
        do_start();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            issue_addr  = 6'(30 + i);
            step();
        end
        idle_in();
        n_tests++; if (pending !== 5'd3) begin n_fail++; $display("FAIL rstmid_pending got %0d want 3", pending); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if ({pending, wr_en} !== 6'd0) begin n_fail++; $display("FAIL rstmid_clear got pend=%0d en=%b want 0 0", pending, wr_en); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            bf_valid = 1'b1;
            step();
            if (wr_en !== 1'b0 || done !== 1'b0 || err_underflow !== 1'b0) bad++;
        end
        idle_in();
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_nowrite got %0d want 0", bad); end
    endtask

    task automatic test_drain_ignore();
        do_start();
        issue_valid = 1'b1;
        issue_addr  = 6'd11;
        issue_last  = 1'b1;
        step();
        issue_addr  = 6'd12;
        issue_last  = 1'b0;
        step();
        idle_in();
        n_tests++; if ({pending, err_overflow} !== {5'd1, 1'b1}) begin n_fail++; $display("FAIL drain_ign got pend=%0d ovf=%b want 1 1", pending, err_overflow); end
        bf_valid = 1'b1;
        bf_data  = pat(11);
        step();
        idle_in();
        n_tests++; if ({wr_en, wr_addr, done} !== {1'b1, 6'd11, 1'b1}) begin n_fail++; $display("FAIL drain_done got en=%b addr=%0d done=%b want 1 11 1", wr_en, wr_addr, done); end
        step();
        n_tests++; if ({wr_en, done} !== 2'b00) begin n_fail++; $display("FAIL drain_pulse got en=%b done=%b want 0 0", wr_en, done); end
    endtask

    task automatic test_long();
        int dones;
        do_start();
        dones = 0;
        for (int c = 0; c <= 72; c++) begin
            issue_valid = (c < 64);
            issue_addr  = 6'(c);
            issue_last  = (c == 63);
            bf_valid    = (c >= 9);
            bf_data     = pat(c - 9);
            step();
            if (done === 1'b1) dones++;
            if (c < 9) begin
                n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL long_early%0d got en=%b want 0", c, wr_en); end
            end else begin
                n_tests++; if ({wr_en, wr_addr, done} !== {1'b1, 6'(c - 9), (c == 72)}) begin n_fail++; $display("FAIL long_wr%0d got en=%b addr=%0d done=%b want 1 %0d %b", c - 9, wr_en, wr_addr, done, c - 9, (c == 72)); end
                n_tests++; if (wr_data !== pat(c - 9)) begin n_fail++; $display("FAIL long_data%0d got %h want %h", c - 9, wr_data, pat(c - 9)); end
            end
        end
        idle_in();
        step();
        n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL long_dones got %0d want 1", dones); end
        n_tests++; if ({wr_en, done, pending} !== 7'd0) begin n_fail++; $display("FAIL long_after got en=%b done=%b pend=%0d want 0 0 0", wr_en, done, pending); end
        n_tests++; if ({err_overflow, err_underflow} !== 2'b00) begin n_fail++; $display("FAIL long_err got %b want 00", {err_overflow, err_underflow}); end
    endtask

    task automatic test_idle_ignore();
        issue_valid = 1'b1;
        issue_addr  = 6'd2;
        bf_valid    = 1'b1;
        step();
        idle_in();
        n_tests++; if ({pending, wr_en, err_overflow, err_underflow} !== 8'd0) begin n_fail++; $display("FAIL idle_ign got pend=%0d en=%b ovf=%b unf=%b want all 0", pending, wr_en, err_overflow, err_underflow); end
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        test_reset();
        test_basic();
        test_overflow();
        test_full_swap();
        test_underflow();
        test_rst_mid();
        test_drain_ignore();
        test_long();
        test_idle_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bf_writeback.md
BF_WRITEBACK -- requirements
Module: bf_writeback

Interface
REQ-001 Parameter COEFF_W, default 24, coefficient width.
REQ-002 Parameter LANES, default 4, coefficients per word.
REQ-003 Parameter AW, default 6, coefficient-RAM word address width.
REQ-004 Parameter DEPTH, default 16, in-flight address queue depth; power of two, at least 2.
REQ-005 clk  input  1  the block's one clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  pulse; begins a new pass and clears all state.
REQ-008 issue_valid  input  1  the feeder issued one word to the butterfly array this cycle.
REQ-009 issue_addr  input  AW  destination RAM word for that issued word.
REQ-010 issue_last  input  1  qualifies issue_valid; marks the final issue of the pass.
REQ-011 bf_valid  input  1  butterfly array result valid.
REQ-012 bf_data  input  LANES*COEFF_W  butterfly array result; lane 0 in LSBs.
REQ-013 wr_en  output  1  coefficient-RAM write strobe.
REQ-014 wr_addr  output  AW  coefficient-RAM write address.
REQ-015 wr_data  output  LANES*COEFF_W  coefficient-RAM write data.
REQ-016 pending  output  clog2(DEPTH)+1  number of addresses queued and not yet written.
REQ-017 done  output  1  one-cycle pulse: the pass has completed.
REQ-018 err_overflow  output  1  sticky: an issue arrived while the queue was full.
REQ-019 err_underflow  output  1  sticky: a result arrived while the queue was empty.

Function
REQ-020 Queue is FIFO: push issue_addr on issue_valid when not full; pop on bf_valid when not empty.
REQ-021 Write is registered, latency 1: cycle after accepted bf_valid, wr_en=1, wr_addr=popped address, wr_data=bf_data captured unmodified.
REQ-022 No push-to-pop bypass: issue_valid & bf_valid with queue empty -> push accepted, pop refused, err_underflow set, no write.
REQ-023 issue_valid & bf_valid with queue full -> both accepted, pending unchanged, no overflow.
REQ-024 issue_valid with queue full and no pop -> address dropped, err_overflow set, pending unchanged.
REQ-025 bf_valid with queue empty -> data dropped, err_underflow set, wr_en stays 0.
REQ-026 Pointers wrap modulo DEPTH; pending ranges 0..DEPTH.
REQ-027 FSM states IDLE, RUN, DRAIN. start in any state -> RUN, with queue cleared, error flags cleared, last flag cleared.
REQ-028 RUN -> DRAIN when issue_valid & issue_last is accepted; a dropped last still sets err_overflow and moves to DRAIN.
REQ-029 DRAIN -> IDLE when pending reaches 0 and the last write has completed; done pulses on the cycle wr_en of the final write is 1.
REQ-030 In DRAIN, further issue_valid is ignored (no push) and sets err_overflow.
REQ-031 In IDLE, issue_valid and bf_valid are ignored; no error flags change.
REQ-032 start coincident with issue_valid or bf_valid: start wins and that cycle's inputs are discarded.
REQ-033 done and the final wr_en are never suppressed by error flags.

Reset
REQ-034 rst -> state IDLE, pointers 0, pending 0, wr_en 0, wr_addr 0, wr_data 0, done 0, err_overflow 0, err_underflow 0.
REQ-035 rst mid-pass discards all queued addresses; no write follows rst.
REQ-036 rst has priority over start.

Structure
REQ-037 COEFF_W, LANES, AW and the FSM state encoding belong in the shared dilithium package.
REQ-038 The address queue is one sub-module, addr_fifo (synchronous, DEPTH x AW, registered count).

Verification
REQ-039 start; issue addrs 5,6,7 on cycles 0-2; bf_valid on cycles 10-12 with data 0x..01, 0x..02, 0x..03 -> writes to 5,6,7 in order on cycles 11-13; done on cycle 13.
REQ-040 17 issues with no results -> 16 queued, 17th dropped, err_overflow=1, pending=16.
REQ-041 bf_valid with empty queue -> err_underflow=1, wr_en=0; next start clears the flag.
REQ-042 Queue full, issue and bf_valid in the same cycle -> pending stays 16, write occurs, no error.
REQ-043 rst asserted with pending=3 -> no writes afterwards, pending=0, done never pulses.
REQ-044 64 issues (addr 0..63, last on 63) with results at a latency of 9 cycles -> 64 writes in address order, single done on final write, both error flags 0.
